// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, instruction field
// positions, flag bit order and the run/halt state type.
package alu_issue_stage_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 13;
  localparam int RD_MSB      = 12;
  localparam int RD_LSB      = 11;
  localparam int RS_MSB      = 10;
  localparam int RS_LSB      = 9;
  localparam int USE_IMM_BIT = 8;
  localparam int IMM_MSB     = 7;
  localparam int IMM_LSB     = 0;
  localparam int RT_MSB      = 7;
  localparam int RT_LSB      = 6;

  // Architectural flags are packed {Z,C,V,N}, Z in the MSB.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_t;

  function automatic logic is_alu_op(logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction valid/ready handshake between the fetch side and the issue stage.
interface alu_issue_stage_if;
  import alu_issue_stage_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_regfile.sv
// NREGS x DW register file: one synchronous write port, three combinational
// read ports (two operand sources and a debug tap).
module alu_regfile #(
  parameter int NREGS = 4,
  parameter int DW    = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] rs_addr,
  output logic [DW-1:0] rs_data,
  input  logic [RW-1:0] rt_addr,
  output logic [DW-1:0] rt_data,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rs_data  = mem[rs_addr];
  assign rt_data  = mem[rt_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage feeding the ALU: operand read with result forwarding,
// one-deep writeback of ALU result and flags, and a run/halt FSM.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int DW    = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_stage_if.slave    ibus,
  input  logic                resume,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [2:0]          alu_opcode,
  input  logic [DW-1:0]       alu_result,
  input  logic                alu_zero,
  input  logic                alu_carry,
  input  logic                alu_overflow,
  input  logic                alu_negative,
  output logic [3:0]          flags,
  output logic                halted,
  input  logic [RW-1:0]       dbg_sel,
  output logic [DW-1:0]       dbg_data
);

  state_t        state;
  logic          ready_q;
  logic          halted_q;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [3:0]    flags_q;

  logic [2:0]    op;
  logic [RW-1:0] rd, rs, rt;
  logic          use_imm;
  logic [7:0]    imm;
  logic          accept, issue;
  logic [DW-1:0] rs_val, rt_val, opa, opb;

  assign op      = ibus.instr[OP_MSB:OP_LSB];
  assign rd      = ibus.instr[RD_MSB:RD_LSB];
  assign rs      = ibus.instr[RS_MSB:RS_LSB];
  assign rt      = ibus.instr[RT_MSB:RT_LSB];
  assign use_imm = ibus.instr[USE_IMM_BIT];
  assign imm     = ibus.instr[IMM_MSB:IMM_LSB];

  assign accept = ibus.instr_valid && ready_q;
  assign issue  = accept && is_alu_op(op);

  alu_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_valid),
    .waddr    (wb_rd),
    .wdata    (alu_result),
    .rs_addr  (rs),
    .rs_data  (rs_val),
    .rt_addr  (rt),
    .rt_data  (rt_val),
    .dbg_addr (dbg_sel),
    .dbg_data (dbg_data)
  );

  // The ALU result for the pending writeback is newer than the register file.
  assign opa = (wb_valid && (wb_rd == rs)) ? alu_result : rs_val;
  assign opb = (wb_valid && (wb_rd == rt)) ? alu_result : rt_val;

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = OP_NOP;
    if (issue) begin
      alu_a      = opa;
      alu_b      = use_imm ? DW'(imm) : opb;
      alu_opcode = op;
    end
  end

  // Writeback register; a reset edge drops whatever was pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      flags_q  <= '0;
    end else begin
      wb_valid <= issue;
      if (issue) wb_rd <= rd;
      if (wb_valid) begin
        flags_q[FLAG_Z] <= alu_zero;
        flags_q[FLAG_C] <= alu_carry;
        flags_q[FLAG_V] <= alu_overflow;
        flags_q[FLAG_N] <= alu_negative;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      ready_q  <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept && (op == OP_HALT)) begin
            state    <= ST_HALT;
            ready_q  <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume) begin
            state    <= ST_RUN;
            ready_q  <= 1'b1;
            halted_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ibus.instr_ready = ready_q;
  assign halted           = halted_q;
  assign flags            = flags_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU stand-in, directed scenarios with
// literal expectations, then randomized traffic checked against a program-order model.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       resume;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_opcode;
  logic       alu_zero, alu_carry, alu_overflow, alu_negative;
  logic [3:0] flags;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if ibus ();

  alu_issue_stage #(.NREGS(4), .DW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ibus         (ibus),
    .resume       (resume),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_negative (alu_negative),
    .flags        (flags),
    .halted       (halted),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  // ALU behaviour: returns {result, Z, C, V, N}; SUB carry is the borrow.
  function automatic logic [11:0] aluEval(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    w = 9'd0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
              v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
              v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      default: r = 8'd0;
    endcase
    return {r, (r == 8'd0), c, v, r[7]};
  endfunction

  always @(posedge clk)
    {alu_result, alu_zero, alu_carry, alu_overflow, alu_negative} <= aluEval(alu_a, alu_b, alu_opcode);

  function automatic logic [15:0] enc(logic [2:0] op, logic [1:0] rd, logic [1:0] rs,
                                      logic ui, logic [7:0] imm);
    return {op, rd, rs, ui, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] ins,
                               input logic res, input logic [1:0] sel);
    @(negedge clk);
    rst              = r;
    ibus.instr_valid = v;
    ibus.instr       = ins;
    resume           = res;
    dbg_sel          = sel;
  endtask

  task automatic idle(input int n, input logic [1:0] sel);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, sel);
  endtask

  // Program-order model: committed registers plus the one result still in flight.
  logic [7:0] mR [4];
  logic [3:0] mFlags;
  bit         mPend, mHalt, modelLive;
  logic [1:0] mPendRd;
  logic [7:0] mPendRes;
  logic [3:0] mPendFlags;

  function automatic logic [7:0] regView(logic [1:0] x);
    return (mPend && mPendRd == x) ? mPendRes : mR[x];
  endfunction

  initial begin
    modelLive = 0;
    forever begin
      @(negedge clk);
      #2;
      begin
        logic [15:0] ins;
        logic [2:0]  op, eop;
        logic [7:0]  ea, eb;
        logic        acc, aluOp;
        logic [11:0] r;
        ins   = ibus.instr;
        op    = ins[15:13];
        acc   = ibus.instr_valid && !mHalt;
        aluOp = acc && (op <= 3'd5);
        ea    = aluOp ? regView(ins[10:9]) : 8'd0;
        eb    = aluOp ? (ins[8] ? ins[7:0] : regView(ins[7:6])) : 8'd0;
        eop   = aluOp ? op : 3'b110;
        if (modelLive) begin
          checkOutput("instr_ready", 16'(ibus.instr_ready), 16'(!mHalt));
          checkOutput("halted", 16'(halted), 16'(mHalt));
          checkOutput("flags", 16'(flags), 16'(mFlags));
          checkOutput("dbg_data", 16'(dbg_data), 16'(mR[dbg_sel]));
          checkOutput("alu_a", 16'(alu_a), 16'(ea));
          checkOutput("alu_b", 16'(alu_b), 16'(eb));
          checkOutput("alu_opcode", 16'(alu_opcode), 16'(eop));
        end
        if (rst) begin
          for (int i = 0; i < 4; i++) mR[i] = 8'd0;
          mFlags    = 4'd0;
          mPend     = 0;
          mHalt     = 0;
          modelLive = 1;
        end else begin
          r = aluEval(ea, eb, op);
          if (mPend) begin
            mR[mPendRd] = mPendRes;
            mFlags      = mPendFlags;
          end
          mPend      = aluOp;
          mPendRd    = ins[12:11];
          mPendRes   = r[11:4];
          mPendFlags = r[3:0];
          if (acc && op == 3'd7) mHalt = 1;
          else if (mHalt && resume) mHalt = 0;
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    ibus.instr_valid = 1'b0;
    ibus.instr       = 16'h0000;
    resume           = 1'b0;
    dbg_sel          = 2'd0;

    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2'd0);
    #3;
    checkOutput("reset_ready", 16'(ibus.instr_ready), 16'h1);
    checkOutput("reset_halted", 16'(halted), 16'h0);
    checkOutput("reset_flags", 16'(flags), 16'h0);
    checkOutput("reset_opcode", 16'(alu_opcode), 16'h6);

    // ADD r1 = r0 + 4, then NOP
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h04), 1'b0, 2'd1);
    #3;
    checkOutput("add_alu_b", 16'(alu_b), 16'h04);
    checkOutput("add_opcode", 16'(alu_opcode), 16'h0);
    applyStimulus(1'b0, 1'b1, enc(OP_NOP, 2'd0, 2'd0, 1'b0, 8'h00), 1'b0, 2'd1);
    idle(1, 2'd1);
    #3;
    checkOutput("add_r1", 16'(dbg_data), 16'h04);
    checkOutput("add_flags", 16'(flags), 16'h0);

    // Back-to-back dependency through forwarding
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h04), 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b1, enc(OP_SUB, 2'd2, 2'd1, 1'b1, 8'h04), 1'b0, 2'd1);
    #3;
    checkOutput("fwd_dbg_unforwarded", 16'(dbg_data), 16'h00);
    checkOutput("fwd_alu_a", 16'(alu_a), 16'h04);
    idle(2, 2'd2);
    #3;
    checkOutput("sub_r2", 16'(dbg_data), 16'h00);
    checkOutput("sub_flags", 16'(flags), 16'b1000);

    // Carry-out and signed overflow
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd3, 2'd0, 1'b1, 8'hFF), 1'b0, 2'd3);
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd3, 2'd3, 1'b1, 8'h01), 1'b0, 2'd3);
    idle(2, 2'd3);
    #3;
    checkOutput("carry_r3", 16'(dbg_data), 16'h00);
    checkOutput("carry_flags", 16'(flags), 16'b1100);
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h7F), 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd1, 2'd1, 1'b1, 8'h01), 1'b0, 2'd1);
    idle(2, 2'd1);
    #3;
    checkOutput("ovf_r1", 16'(dbg_data), 16'h80);
    checkOutput("ovf_flags", 16'(flags), 16'b0011);

    // HALT with a queued instruction held valid
    applyStimulus(1'b0, 1'b1, enc(OP_HALT, 2'd0, 2'd0, 1'b0, 8'h00), 1'b0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd2, 2'd0, 1'b1, 8'h55), 1'b0, 2'd2);
      #3;
      checkOutput("halt_ready", 16'(ibus.instr_ready), 16'h0);
      checkOutput("halt_halted", 16'(halted), 16'h1);
      checkOutput("halt_r2", 16'(dbg_data), 16'h00);
    end
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd2, 2'd0, 1'b1, 8'h55), 1'b1, 2'd2);
    #3;
    checkOutput("resume_cycle_ready", 16'(ibus.instr_ready), 16'h0);
    checkOutput("resume_cycle_opcode", 16'(alu_opcode), 16'h6);
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd2, 2'd0, 1'b1, 8'h55), 1'b0, 2'd2);
    #3;
    checkOutput("after_resume_ready", 16'(ibus.instr_ready), 16'h1);
    checkOutput("after_resume_alu_b", 16'(alu_b), 16'h55);
    idle(2, 2'd2);
    #3;
    checkOutput("queued_r2", 16'(dbg_data), 16'h55);

    // Reset discards the pending writeback
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h09), 1'b0, 2'd1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2'd1);
    #3;
    checkOutput("rst_r1", 16'(dbg_data), 16'h00);
    checkOutput("rst_flags", 16'(flags), 16'h0);
    checkOutput("rst_halted", 16'(halted), 16'h0);
    idle(1, 2'd1);
    #3;
    checkOutput("rst_r1_later", 16'(dbg_data), 16'h00);

    // Register-register XOR with rt forwarded
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h0C), 1'b0, 2'd3);
    applyStimulus(1'b0, 1'b1, enc(OP_ADD, 2'd2, 2'd0, 1'b1, 8'h0A), 1'b0, 2'd3);
    applyStimulus(1'b0, 1'b1, enc(OP_XOR, 2'd3, 2'd1, 1'b0, {2'd2, 6'd0}), 1'b0, 2'd3);
    #3;
    checkOutput("xor_alu_a", 16'(alu_a), 16'h0C);
    checkOutput("xor_alu_b", 16'(alu_b), 16'h0A);
    idle(2, 2'd3);
    #3;
    checkOutput("xor_r3", 16'(dbg_data), 16'h06);
    checkOutput("xor_flags", 16'(flags), 16'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ins;
      logic [2:0]  op;
      ins = 16'($urandom);
      op  = 3'($urandom_range(0, 7));
      if (op == 3'd7 && $urandom_range(0, 1) == 0) op = 3'd0;
      ins[15:13] = op;
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), ins,
                    ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
    end
    idle(2, 2'd0);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
